// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
//
// Bus between the datapath/register file and the display scan controller.
//
// Signals:
//   data       packed hex digits; digit k is data[4k+3:4k], digit 0 rightmost
//   digit_en   per-digit enable; 0 keeps that digit dark
//   load       capture data/digit_en into the controller's shadow registers
//   nums       nibble for the seven-segment decoder (registered)
//   anode      active-low digit enables (registered)
//   blank      high when every anode is off (registered)
//   frame_tick one-cycle pulse at the end of each full scan frame
//
// Modports:
//   master  the datapath side: drives data/digit_en/load, observes outputs
//   slave   the scan controller
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [3:0]              nums;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    blank;
  logic                    frame_tick;

  modport master (
    output data, digit_en, load,
    input  nums, anode, blank, frame_tick
  );

  modport slave (
    input  data, digit_en, load,
    output nums, anode, blank, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode display.
// Walks the digits of a shadowed hex word one slot at a time, presenting
// the current nibble to the seven-segment decoder and pulling that digit's
// anode low. Each slot starts with a blanking interval (all anodes off) so
// the previous digit's segments never ghost onto the next anode.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_ctrl_if.slave (data, digit_en, load in;
//          nums, anode, blank, frame_tick out)
//
// Parameters:
//   NUM_DIGITS    number of multiplexed digits (>= 1, any value)
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  cycles of blanking at the start of each slot
//                 (0 <= BLANK_CYCLES < REFRESH_DIV)
//
// All outputs are registered and reflect counter/shadow state from the
// previous cycle; there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Counters and shadow state
  logic [CNT_W-1:0]        div_cnt_reg,  div_cnt_next;
  logic [IDX_W-1:0]        dig_idx_reg,  dig_idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_data_reg;
  logic [NUM_DIGITS-1:0]   shadow_en_reg;

  // Registered outputs
  logic [3:0]              nums_reg,       nums_next;
  logic [NUM_DIGITS-1:0]   anode_reg,      anode_next;
  logic                    blank_reg,      blank_next;
  logic                    frame_tick_reg, frame_tick_next;

  logic                    slot_end;
  logic                    in_blank;
  logic                    cur_en;
  logic [3:0]              digit_nib [NUM_DIGITS];

  // Split the shadow word into per-digit nibbles so the current digit can
  // be picked with a plain array index.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign digit_nib[gi] = shadow_data_reg[4*gi +: 4];
    end
  endgenerate

  // Blanking phase decode. With no blanking the compare would be against
  // zero and always false, so it is elaborated away instead.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
      assign in_blank = (div_cnt_reg < BLANK_LIM);
    end
  endgenerate

  assign slot_end = (div_cnt_reg == CNT_LAST);
  assign cur_en   = shadow_en_reg[dig_idx_reg];

  // Only the anode matching dig_idx can go low, which guarantees at most
  // one lit digit in any cycle.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign anode_next[gi] = ~(~in_blank & cur_en &
                                (dig_idx_reg == IDX_W'(gi)));
    end
  endgenerate

  always_comb begin
    div_cnt_next    = div_cnt_reg + CNT_W'(1);
    dig_idx_next    = dig_idx_reg;
    nums_next       = digit_nib[dig_idx_reg];
    blank_next      = in_blank | ~cur_en;
    frame_tick_next = slot_end & (dig_idx_reg == IDX_LAST);

    if (slot_end) begin
      div_cnt_next = '0;
      // Explicit wrap: NUM_DIGITS need not be a power of two.
      if (dig_idx_reg == IDX_LAST) begin
        dig_idx_next = '0;
      end else begin
        dig_idx_next = dig_idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg     <= '0;
      dig_idx_reg     <= '0;
      shadow_data_reg <= '0;
      shadow_en_reg   <= '0;
      nums_reg        <= '0;
      anode_reg       <= '1;
      blank_reg       <= 1'b1;
      frame_tick_reg  <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      dig_idx_reg    <= dig_idx_next;
      nums_reg       <= nums_next;
      anode_reg      <= anode_next;
      blank_reg      <= blank_next;
      frame_tick_reg <= frame_tick_next;
      // A load lands in the shadow now; the outputs pick it up on the
      // following edge, independent of where the scan counters are.
      if (bus.load) begin
        shadow_data_reg <= bus.data;
        shadow_en_reg   <= bus.digit_en;
      end
    end
  end

  assign bus.nums       = nums_reg;
  assign bus.anode      = anode_reg;
  assign bus.blank      = blank_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed, table-driven bench for seg_scan_ctrl with NUM_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2. Each table record describes one 8-cycle
// digit slot; hand-written sequences cover reset, shadow hold, mid-slot
// load and frame_tick spacing.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // output samples taken since the last reset release

  typedef struct {
    logic        load;       // load data/en at the frame boundary before this slot
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  exp_anode;  // anode during the drive part of the slot
    logic [3:0]  exp_nums;
    logic        exp_blank;  // blank during the drive part of the slot
    logic        exp_tick;   // frame_tick in the last cycle of the slot
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (sample %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] an, input logic [3:0] nu,
                         input logic bl, input logic tk);
    chk({name, " anode"}, 16'(bus.anode), 16'(an));
    chk({name, " nums"},  16'(bus.nums),  16'(nu));
    chk({name, " blank"}, 16'(bus.blank), 16'(bl));
    chk({name, " tick"},  16'(bus.frame_tick), 16'(tk));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run to the last edge of a frame and load on that very edge, so the
  // shadow update coincides with the slot boundary; afterwards cyc%FRAME==0.
  task automatic align_and_load(input logic [15:0] d, input logic [3:0] e);
    while (cyc % FRAME != FRAME - 1) tick();
    bus.data     = d;
    bus.digit_en = e;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("frame tick on load edge", 16'(bus.frame_tick), 16'd1);
    $display("load data=%h en=%b at sample %0d", d, e, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int nticks;
    int tpos [3];

    //           load  data      en       anode    nums  blank tick
    vecs[0]  = '{1'b1, 16'h4321, 4'hF,    4'b1110, 4'h1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h4321, 4'hF,    4'b1101, 4'h2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h4321, 4'hF,    4'b1011, 4'h3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h4321, 4'hF,    4'b0111, 4'h4, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 16'h4321, 4'hF,    4'b1110, 4'h1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h4321, 4'hF,    4'b1101, 4'h2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h4321, 4'hF,    4'b1011, 4'h3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h4321, 4'hF,    4'b0111, 4'h4, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 16'hABCD, 4'b1011, 4'b1110, 4'hD, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'hABCD, 4'b1011, 4'b1101, 4'hC, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'hABCD, 4'b1011, 4'b1111, 4'hB, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'hABCD, 4'b1011, 4'b0111, 4'hA, 1'b0, 1'b1};

    bus.data     = '0;
    bus.digit_en = '0;
    bus.load     = 1'b0;

    // Asynchronous reset in the middle of a clock period.
    #12;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 4'hF, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_out("reset held", 4'hF, 4'h0, 1'b1, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    chk_out("first cycle after reset", 4'hF, 4'h0, 1'b1, 1'b0);

    // Table-driven slot checks.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].load) align_and_load(vecs[i].data, vecs[i].en);
      for (int c = 0; c < RD; c++) begin
        tick();
        if (c < BC)
          chk_out($sformatf("vec%0d blank c%0d", i, c), 4'hF, vecs[i].exp_nums, 1'b1, 1'b0);
        else
          chk_out($sformatf("vec%0d drive c%0d", i, c), vecs[i].exp_anode, vecs[i].exp_nums,
                  vecs[i].exp_blank, (c == RD - 1) ? vecs[i].exp_tick : 1'b0);
      end
      $display("slot vec%0d data=%h en=%b anode=%b nums=%h", i, vecs[i].data, vecs[i].en,
               vecs[i].exp_anode, vecs[i].exp_nums);
    end

    // Shadow hold: data changes without load must not reach the display.
    align_and_load(16'h1111, 4'hF);
    bus.data = 16'hFFFF;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.nums !== 4'h1) bad++;
    end
    chk("shadow hold nums changes", 16'(bad), 16'd0);
    $display("shadow hold: 64 cycles with data=FFFF and load=0");

    // Load mid-drive of slot 1: the very next output cycle shows the new nibble.
    while (cyc % FRAME != 12) tick();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk_out("load edge old data", 4'b1101, 4'h1, 1'b0, 1'b0);
    tick();
    chk_out("mid-drive load new data", 4'b1101, 4'hF, 1'b0, 1'b0);
    $display("mid-drive load: nums=%h anode=%b", bus.nums, bus.anode);

    // Reset during the drive part of slot 2.
    while (cyc % FRAME != 21) tick();
    chk("pre-reset slot2 anode", 16'(bus.anode), 16'(4'b1011));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid-drive async reset", 4'hF, 4'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_out("mid-drive reset held", 4'hF, 4'h0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b1;
    cyc   = 0;

    // Free run after release: dark display, frame ticks every FRAME cycles.
    bad    = 0;
    nticks = 0;
    tpos   = '{0, 0, 0};
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (bus.anode !== 4'hF || bus.blank !== 1'b1 || bus.nums !== 4'h0) bad++;
      if (bus.frame_tick === 1'b1) begin
        if (nticks < 3) tpos[nticks] = cyc;
        nticks++;
      end
    end
    chk("dark after reset", 16'(bad), 16'd0);
    chk("frame tick count", 16'(nticks), 16'd3);
    chk("frame tick 0 pos", 16'(tpos[0]), 16'(FRAME));
    chk("frame tick 1 pos", 16'(tpos[1]), 16'(2 * FRAME));
    chk("frame tick 2 pos", 16'(tpos[2]), 16'(3 * FRAME));
    $display("free run: %0d ticks at %0d %0d %0d", nticks, tpos[0], tpos[1], tpos[2]);

    // A fresh load lights the display again.
    align_and_load(16'h000B, 4'b0001);
    tick();
    chk_out("relit blank c0", 4'hF, 4'hB, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("relit drive c2", 4'b1110, 4'hB, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
